// File: rtl/fft_address_generator.sv
// ---------------------------------------------------------------------------
// fft_address_generator
//
// Address and enable generator for an in-place radix-2 DIT FFT of 2**LOG2N
// points. It works with two ping-pong buffer memories (mem1, mem2), each with
// ports a and b, and with one twiddle ROM.
//
// On every clock the (stage, butterfly index) pair from the control sequencer
// becomes:
//   * registered read addresses/enables for the twiddle ROM and the source
//     memory. These appear one cycle after the inputs are sampled.
//   * write addresses/enables for the destination memory. These appear
//     BF_LATENCY cycles after the matching read outputs.
//
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_stage    0..LOG2N-1 butterfly stage, LOG2N readout, above that idle
//   i_pair     butterfly index (butterfly stages) or sample index (readout)
//   o_rd_addr  [0] twiddle ROM, [1] mem1a, [2] mem1b, [3] mem2a, [4] mem2b
//   o_rd_en    read enables, same indexing as o_rd_addr
//   o_wr_addr  [0] mem1a, [1] mem1b, [2] mem2a, [3] mem2b
//   o_wr_en    write enables, same indexing as o_wr_addr
//
// Build option:
//   ADDR_GEN_OUT_BITREV_EN  when defined, the readout stage addresses mem2a
//                           with the bit-reversed sample index. This suits
//                           results stored in bit-reversed order.
// ---------------------------------------------------------------------------
module fft_address_generator #(
    parameter int LOG2N      = 9,
    parameter int BF_LATENCY = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_stage,
    input  logic [LOG2N-1:0] i_pair,
    output logic [LOG2N-1:0] o_rd_addr [0:4],
    output logic [0:4]       o_rd_en,
    output logic [LOG2N-1:0] o_wr_addr [0:3],
    output logic [0:3]       o_wr_en
);

    localparam int         AW        = LOG2N;
    localparam logic [3:0] OUT_STAGE = 4'(LOG2N);

    // One in-flight butterfly write. The destination is captured when the
    // write is issued, so a stage change mid-pipeline cannot redirect it.
    typedef struct packed {
        logic          valid;
        logic          dest_mem2;
        logic [AW-1:0] top;
        logic [AW-1:0] bot;
    } wr_entry_t;

    logic [AW-1:0] half;
    logic [AW-1:0] k;
    logic [AW-1:0] grp;
    logic [AW-1:0] top;
    logic [AW-1:0] bot;
    logic [AW-1:0] tw;
    logic [AW-1:0] out_addr;
    logic [3:0]    stage_p1;
    logic [3:0]    tw_shift;
    logic          is_bf;
    logic          is_out;

    logic [AW-1:0] rd_addr_next [0:4];
    logic [0:4]    rd_en_next;
    logic [AW-1:0] wr_addr_next [0:3];
    logic [0:3]    wr_en_next;
    wr_entry_t     entry_next;
    wr_entry_t     pipe_reg [0:BF_LATENCY-1];

    // Butterfly operand addresses for stage s:
    //   top = grp*2*half + k, bot = top + half, tw = k << (LOG2N-1-s).
    // The terms are only meaningful when is_bf is set, because every
    // consumer is gated by is_bf.
    always_comb begin
        stage_p1 = i_stage + 4'd1;
        tw_shift = OUT_STAGE - 4'd1 - i_stage;
        half     = AW'(1) << i_stage;
        k        = i_pair & (half - AW'(1));
        grp      = i_pair >> i_stage;
        top      = (grp << stage_p1) | k;
        // k < half, so the OR is the same as adding half
        bot      = top | half;
        tw       = (k << tw_shift) & {1'b0, {(AW-1){1'b1}}};
    end

    // The butterfly index range is half the transform size, so the top bit
    // of i_pair flags an out-of-range pair.
    assign is_bf  = (i_stage < OUT_STAGE) && !i_pair[AW-1];
    assign is_out = (i_stage == OUT_STAGE);

`ifdef ADDR_GEN_OUT_BITREV_EN
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
            assign out_addr[gi] = i_pair[AW-1-gi];
        end
    endgenerate
`else
    assign out_addr = i_pair;
`endif

    // Read side and the new write-pipeline entry. Even stages read mem1 and
    // write mem2. Odd stages read mem2 and write mem1.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rd_addr_next[i] = '0;
        end
        rd_en_next = '0;
        entry_next = '0;
        if (is_bf) begin
            rd_en_next[0]        = 1'b1;
            rd_addr_next[0]      = tw;
            entry_next.valid     = 1'b1;
            entry_next.dest_mem2 = ~i_stage[0];
            entry_next.top       = top;
            entry_next.bot       = bot;
            if (!i_stage[0]) begin
                rd_en_next[1]   = 1'b1;
                rd_en_next[2]   = 1'b1;
                rd_addr_next[1] = top;
                rd_addr_next[2] = bot;
            end else begin
                rd_en_next[3]   = 1'b1;
                rd_en_next[4]   = 1'b1;
                rd_addr_next[3] = top;
                rd_addr_next[4] = bot;
            end
        end else if (is_out) begin
            rd_en_next[3]   = 1'b1;
            rd_addr_next[3] = out_addr;
        end
    end

    // Decode the oldest pipeline entry into destination write ports.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_addr_next[i] = '0;
        end
        wr_en_next = '0;
        if (pipe_reg[BF_LATENCY-1].valid) begin
            if (pipe_reg[BF_LATENCY-1].dest_mem2) begin
                wr_en_next[2]   = 1'b1;
                wr_en_next[3]   = 1'b1;
                wr_addr_next[2] = pipe_reg[BF_LATENCY-1].top;
                wr_addr_next[3] = pipe_reg[BF_LATENCY-1].bot;
            end else begin
                wr_en_next[0]   = 1'b1;
                wr_en_next[1]   = 1'b1;
                wr_addr_next[0] = pipe_reg[BF_LATENCY-1].top;
                wr_addr_next[1] = pipe_reg[BF_LATENCY-1].bot;
            end
        end
    end

    // Registered read outputs, the head of the write pipeline, and the
    // registered write outputs. The head loads on the same edge as the read
    // outputs. The write outputs then register BF_LATENCY edges later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 5; i++) begin
                o_rd_addr[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                o_wr_addr[i] <= '0;
            end
            o_rd_en     <= '0;
            o_wr_en     <= '0;
            pipe_reg[0] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                o_rd_addr[i] <= rd_addr_next[i];
            end
            for (int i = 0; i < 4; i++) begin
                o_wr_addr[i] <= wr_addr_next[i];
            end
            o_rd_en     <= rd_en_next;
            o_wr_en     <= wr_en_next;
            pipe_reg[0] <= entry_next;
        end
    end

    // Remaining delay stages of the write pipeline.
    generate
        for (genvar gi = 1; gi < BF_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    pipe_reg[gi] <= '0;
                end else begin
                    pipe_reg[gi] <= pipe_reg[gi-1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fft_address_generator.sv
// ---------------------------------------------------------------------------
// Testbench for fft_address_generator (LOG2N = 9, BF_LATENCY = 3).
// Each applied input is kept in a history queue. The expected outputs come
// from FFT index arithmetic on that history: the read outputs belong to the
// last sampled input, and the write outputs to the input sampled BF edges
// earlier.
// ---------------------------------------------------------------------------
module tb_fft_address_generator;

    localparam int BF = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] stage = 4'd15;
    logic [8:0] pair  = 9'd0;

    logic [8:0] rd_addr [0:4];
    logic [0:4] rd_en;
    logic [8:0] wr_addr [0:3];
    logic [0:3] wr_en;

    logic [49:0] act_rd;
    logic [39:0] act_wr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int st;
        int pr;
    } in_t;

    in_t hist[$];

    always #5 clk = ~clk;

    fft_address_generator #(
        .LOG2N      (9),
        .BF_LATENCY (BF)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_stage   (stage),
        .i_pair    (pair),
        .o_rd_addr (rd_addr),
        .o_rd_en   (rd_en),
        .o_wr_addr (wr_addr),
        .o_wr_en   (wr_en)
    );

    assign act_rd = {rd_en, rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3], rd_addr[4]};
    assign act_wr = {wr_en, wr_addr[0], wr_addr[1], wr_addr[2], wr_addr[3]};

    // ---------------- reference model ----------------
    function automatic int bitrev9(int v);
        int r = 0;
        for (int b = 0; b < 9; b++) begin
            if (((v >> b) & 1) != 0) r = r | (1 << (8 - b));
        end
        return r;
    endfunction

    function automatic logic [49:0] model_rd(in_t x);
        logic [0:4] en;
        logic [8:0] a [0:4];
        en = '0;
        for (int i = 0; i < 5; i++) a[i] = '0;
        if (x.st <= 8 && x.pr < 256) begin
            int half = 1 << x.st;
            int k    = x.pr % half;
            int grp  = x.pr / half;
            int top  = grp * 2 * half + k;
            int bot  = top + half;
            en[0] = 1'b1;
            a[0]  = 9'(k * (256 / half));
            if (x.st % 2 == 0) begin
                en[1] = 1'b1; en[2] = 1'b1; a[1] = 9'(top); a[2] = 9'(bot);
            end else begin
                en[3] = 1'b1; en[4] = 1'b1; a[3] = 9'(top); a[4] = 9'(bot);
            end
        end else if (x.st == 9) begin
            en[3] = 1'b1;
`ifdef ADDR_GEN_OUT_BITREV_EN
            a[3] = 9'(bitrev9(x.pr));
`else
            a[3] = 9'(x.pr);
`endif
        end
        return {en, a[0], a[1], a[2], a[3], a[4]};
    endfunction

    function automatic logic [39:0] model_wr(in_t x);
        logic [0:3] en;
        logic [8:0] a [0:3];
        en = '0;
        for (int i = 0; i < 4; i++) a[i] = '0;
        if (x.st <= 8 && x.pr < 256) begin
            int half = 1 << x.st;
            int top  = (x.pr / half) * 2 * half + (x.pr % half);
            if (x.st % 2 == 0) begin
                en[2] = 1'b1; en[3] = 1'b1; a[2] = 9'(top); a[3] = 9'(top + half);
            end else begin
                en[0] = 1'b1; en[1] = 1'b1; a[0] = 9'(top); a[1] = 9'(top + half);
            end
        end
        return {en, a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [49:0] exp_rd();
        if (hist.size() == 0) return '0;
        return model_rd(hist[hist.size() - 1]);
    endfunction

    function automatic logic [39:0] exp_wr();
        if (hist.size() <= BF) return '0;
        return model_wr(hist[hist.size() - 1 - BF]);
    endfunction

    // Apply one input at the falling edge. Let the rising edge sample it,
    // then return at the next falling edge, where the outputs are stable.
    task automatic tick(int st, int pr);
        in_t e;
        stage = 4'(st);
        pair  = 9'(pr);
        @(posedge clk);
        if (rst_n) begin
            e.st = st;
            e.pr = pr;
            hist.push_back(e);
        end
        @(negedge clk);
        $display("txn st=%0d pr=%0d rd_en=%b wr_en=%b", st, pr, rd_en, wr_en);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (act_rd !== 50'd0) begin bad++; $display("FAIL reset_rd got=%h want=0", act_rd); end
        total++;
        if (act_wr !== 40'd0) begin bad++; $display("FAIL reset_wr got=%h want=0", act_wr); end
        rst_n = 1'b1;
        hist.delete();
        for (int i = 0; i < 5; i++) begin
            tick(15, 0);
            total++;
            if (act_rd !== 50'd0) begin bad++; $display("FAIL idle_rd got=%h want=0", act_rd); end
            total++;
            if (act_wr !== 40'd0) begin bad++; $display("FAIL idle_wr got=%h want=0", act_wr); end
        end
    endtask

    task automatic test_stage0();
        tick(0, 1);
        total++;
        if (rd_en !== 5'b11100) begin bad++; $display("FAIL s0_rd_en got=%b want=11100", rd_en); end
        total++;
        if (rd_addr[0] !== 9'd0 || rd_addr[1] !== 9'd2 || rd_addr[2] !== 9'd3) begin
            bad++;
            $display("FAIL s0_rd_addr got=%0d,%0d,%0d want=0,2,3", rd_addr[0], rd_addr[1], rd_addr[2]);
        end
        for (int i = 0; i < BF; i++) begin
            tick(15, 0);
            total++;
            if (act_wr !== exp_wr()) begin bad++; $display("FAIL s0_wr_model got=%h want=%h", act_wr, exp_wr()); end
        end
        total++;
        if (wr_en !== 4'b0011 || wr_addr[2] !== 9'd2 || wr_addr[3] !== 9'd3) begin
            bad++;
            $display("FAIL s0_wr got=%b %0d,%0d want=0011 2,3", wr_en, wr_addr[2], wr_addr[3]);
        end
    endtask

    task automatic test_stage1_and_8();
        tick(1, 1);
        total++;
        if (rd_en !== 5'b10011 || rd_addr[0] !== 9'd128 || rd_addr[3] !== 9'd1 || rd_addr[4] !== 9'd3) begin
            bad++;
            $display("FAIL s1_rd got=%b %0d,%0d,%0d want=10011 128,1,3", rd_en, rd_addr[0], rd_addr[3], rd_addr[4]);
        end
        tick(8, 5);
        total++;
        if (rd_en !== 5'b11100 || rd_addr[0] !== 9'd5 || rd_addr[1] !== 9'd5 || rd_addr[2] !== 9'd261) begin
            bad++;
            $display("FAIL s8_rd got=%b %0d,%0d,%0d want=11100 5,5,261", rd_en, rd_addr[0], rd_addr[1], rd_addr[2]);
        end
        tick(15, 0);
        tick(15, 0);
        total++;
        if (wr_en !== 4'b1100 || wr_addr[0] !== 9'd1 || wr_addr[1] !== 9'd3) begin
            bad++;
            $display("FAIL s1_wr got=%b %0d,%0d want=1100 1,3", wr_en, wr_addr[0], wr_addr[1]);
        end
        tick(15, 0);
        total++;
        if (wr_en !== 4'b0011 || wr_addr[2] !== 9'd5 || wr_addr[3] !== 9'd261) begin
            bad++;
            $display("FAIL s8_wr got=%b %0d,%0d want=0011 5,261", wr_en, wr_addr[2], wr_addr[3]);
        end
    endtask

    task automatic test_readout();
        int want_addr;
`ifdef ADDR_GEN_OUT_BITREV_EN
        want_addr = 256;
`else
        want_addr = 1;
`endif
        tick(9, 1);
        total++;
        if (rd_en !== 5'b00010 || rd_addr[3] !== 9'(want_addr)) begin
            bad++;
            $display("FAIL readout_rd got=%b %0d want=00010 %0d", rd_en, rd_addr[3], want_addr);
        end
        for (int i = 0; i < BF + 1; i++) begin
            tick(15, 0);
            total++;
            if (wr_en !== 4'b0000) begin bad++; $display("FAIL readout_wr got=%b want=0000", wr_en); end
        end
    endtask

    task automatic test_back_to_back();
        int p0 = $urandom_range(0, 255);
        int p1 = $urandom_range(0, 255);
        tick(0, p0);
        tick(1, p1);
        tick(3, 300);
        total++;
        if (rd_en !== 5'b00000 || act_rd !== 50'd0) begin bad++; $display("FAIL bubble_rd got=%h want=0", act_rd); end
        for (int i = 0; i < BF + 2; i++) begin
            tick(15, 0);
            total++;
            if (act_wr !== exp_wr()) begin bad++; $display("FAIL b2b_wr got=%h want=%h", act_wr, exp_wr()); end
            if (i == BF - 3) begin
                total++;
                if (wr_en !== 4'b0011) begin bad++; $display("FAIL b2b_first got=%b want=0011", wr_en); end
            end else if (i == BF - 2) begin
                total++;
                if (wr_en !== 4'b1100) begin bad++; $display("FAIL b2b_second got=%b want=1100", wr_en); end
            end else begin
                total++;
                if (wr_en !== 4'b0000) begin bad++; $display("FAIL b2b_extra got=%b want=0000", wr_en); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int st = $urandom_range(0, 11);
            int pr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 255);
            if ($urandom_range(0, 15) == 0) st = $urandom_range(12, 15);
            tick(st, pr);
            total++;
            if (act_rd !== exp_rd()) begin bad++; $display("FAIL rand_rd st=%0d pr=%0d got=%h want=%h", st, pr, act_rd, exp_rd()); end
            total++;
            if (act_wr !== exp_wr()) begin bad++; $display("FAIL rand_wr st=%0d pr=%0d got=%h want=%h", st, pr, act_wr, exp_wr()); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < BF + 1; i++) tick(15, 0);
        tick(0, $urandom_range(0, 255));
        tick(1, $urandom_range(0, 255));
        tick(2, $urandom_range(0, 255));
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (act_rd !== 50'd0) begin bad++; $display("FAIL async_rst_rd got=%h want=0", act_rd); end
        total++;
        if (act_wr !== 40'd0) begin bad++; $display("FAIL async_rst_wr got=%h want=0", act_wr); end
        hist.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < BF + 2; i++) begin
            tick(15, 0);
            total++;
            if (wr_en !== 4'b0000) begin bad++; $display("FAIL post_rst_wr got=%b want=0000", wr_en); end
            total++;
            if (act_rd !== exp_rd()) begin bad++; $display("FAIL post_rst_rd got=%h want=%h", act_rd, exp_rd()); end
        end
    endtask

    initial begin
        test_reset();
        test_stage0();
        test_stage1_and_8();
        test_readout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
